// File: rtl/router_dst_port_array.sv
// router_dst_port_array: destination-side output stage of the router.
// NUM_CH independent first-word-fall-through FIFOs, one per destination
// interface, all written from the shared din bus and drained by read_enb.
// Optional feature macro: ROUTER_DST_SOFTRST_EN builds a per-channel stall
// counter that flushes a channel whose consumer has not read for TIMEOUT
// consecutive cycles and pulses soft_rst for that channel.
module router_dst_port_array #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic [NUM_CH-1:0]        read_enb,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic [NUM_CH-1:0]        valid_out,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        soft_rst
);

    // Address bits plus one wrap bit so a full FIFO differs from an empty one.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
        logic [PW-1:0]     count;
        logic              is_valid, is_full;
        logic              pop, push, flush;
        logic              soft_rst_q, soft_rst_d;

        assign count    = wr_ptr_q - rd_ptr_q;
        assign is_valid = (count != '0);
        assign is_full  = (count == PW'(DEPTH));

        // A pop needs data; a write into a full FIFO only lands if the same
        // cycle pops, and a write racing a timeout flush is discarded.
        assign pop  = read_enb[g] && is_valid;
        assign push = wr_en[g] && (!is_full || pop) && !flush;

`ifdef ROUTER_DST_SOFTRST_EN
        localparam int SW = $clog2(TIMEOUT + 1);
        logic [SW-1:0] stall_q, stall_d;

        // Count consecutive cycles with data waiting and no read; the cycle
        // that would make it TIMEOUT flushes the channel instead.
        always_comb begin
            stall_d = stall_q;
            flush   = 1'b0;
            if (!is_valid || pop) begin
                stall_d = '0;
            end else if (stall_q == SW'(TIMEOUT - 1)) begin
                flush   = 1'b1;
                stall_d = '0;
            end else if (stall_q != SW'(TIMEOUT)) begin
                stall_d = stall_q + 1'b1;
            end
        end

        // Stall counter register.
        always_ff @(posedge clk) begin
            if (rst) stall_q <= '0;
            else     stall_q <= stall_d;
        end

        assign soft_rst_d = flush;
`else
        assign flush      = 1'b0;
        assign soft_rst_d = 1'b0;
`endif

        // Next pointer values: a flush empties the channel outright.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end

        // Pointer and soft reset pulse registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                soft_rst_q <= 1'b0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                soft_rst_q <= soft_rst_d;
            end
        end

        // Storage array; contents need no reset because dout is gated by valid.
        always_ff @(posedge clk) begin
            if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= din;
        end

        assign dout[g*DATA_W +: DATA_W] = is_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        assign valid_out[g]             = is_valid;
        assign full[g]                  = is_full;
        assign soft_rst[g]              = soft_rst_q;
    end

endmodule

// File: tb/tb_router_dst_port_array.sv
// Self-checking bench for router_dst_port_array (NUM_CH=3, DATA_W=8,
// DEPTH=16, TIMEOUT=30). Timeout scenarios follow ROUTER_DST_SOFTRST_EN.
module tb_router_dst_port_array;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        wr_en;
    logic [DATA_W-1:0]        din;
    logic [NUM_CH-1:0]        read_enb;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic [NUM_CH-1:0]        valid_out;
    logic [NUM_CH-1:0]        full;
    logic [NUM_CH-1:0]        soft_rst;

    int n_checks = 0;
    int n_errors = 0;

    router_dst_port_array #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(30)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .din      (din),
        .read_enb (read_enb),
        .dout     (dout),
        .valid_out(valid_out),
        .full     (full),
        .soft_rst (soft_rst)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0]        wr;
        logic [DATA_W-1:0]        d;
        logic [NUM_CH-1:0]        rd;
        logic [NUM_CH-1:0]        exp_valid;
        logic [NUM_CH-1:0]        exp_full;
        logic [NUM_CH*DATA_W-1:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic [NUM_CH-1:0] w, input logic [DATA_W-1:0] d,
                       input logic [NUM_CH-1:0] r);
        wr_en    = w;
        din      = d;
        read_enb = r;
        @(posedge clk);
        #1;
        wr_en    = '0;
        read_enb = '0;
    endtask

    function automatic logic [DATA_W-1:0] ch_dout(input int ch);
        return dout[ch*DATA_W +: DATA_W];
    endfunction

    initial begin
        logic [NUM_CH-1:0] seen_srst;

        // Reset with writes pending on every channel.
        rst      = 1'b1;
        wr_en    = '1;
        din      = 8'hFF;
        read_enb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(valid_out), 32'h0);
        chk("reset_full",  32'(full),      32'h0);
        chk("reset_dout",  32'(dout),      32'h0);
        chk("reset_srst",  32'(soft_rst),  32'h0);
        rst   = 1'b0;
        wr_en = '0;

        // Directed vectors: {wr_en, din, read_enb, valid, full, dout}.
        vecs[0] = '{3'b001, 8'h11, 3'b000, 3'b001, 3'b000, 24'h00_00_11};
        vecs[1] = '{3'b010, 8'h22, 3'b000, 3'b011, 3'b000, 24'h00_22_11};
        vecs[2] = '{3'b100, 8'h33, 3'b001, 3'b110, 3'b000, 24'h33_22_00};
        vecs[3] = '{3'b011, 8'h44, 3'b000, 3'b111, 3'b000, 24'h33_22_44};
        vecs[4] = '{3'b000, 8'h00, 3'b111, 3'b010, 3'b000, 24'h00_44_00};
        vecs[5] = '{3'b000, 8'h00, 3'b001, 3'b010, 3'b000, 24'h00_44_00};
        vecs[6] = '{3'b010, 8'h55, 3'b010, 3'b010, 3'b000, 24'h00_55_00};
        vecs[7] = '{3'b000, 8'h00, 3'b010, 3'b000, 3'b000, 24'h00_00_00};
        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].wr, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_full", i),  32'(full),      32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_dout", i),  32'(dout),      32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_srst", i),  32'(soft_rst),  32'h0);
        end

        // Fill ch1 to the brim, drop an overflow write, drain in order.
        for (int k = 1; k <= DEPTH; k++) begin
            cyc(3'b010, 8'(k), 3'b000);
            if (k == DEPTH - 1) chk("ch1_full_at_15", 32'(full[1]), 32'h0);
        end
        chk("ch1_full_at_16", 32'(full[1]), 32'h1);
        cyc(3'b010, 8'hAA, 3'b000);
        chk("ch1_full_after_drop", 32'(full[1]), 32'h1);
        for (int k = 1; k <= DEPTH; k++) begin
            chk($sformatf("ch1_pop%0d", k), 32'(ch_dout(1)), 32'(k));
            cyc(3'b000, 8'h00, 3'b010);
        end
        chk("ch1_empty_valid", 32'(valid_out[1]), 32'h0);
        chk("ch1_empty_dout",  32'(ch_dout(1)),   32'h0);

        // Full ch0, then simultaneous write and pop: write accepted, still full.
        for (int k = 0; k < DEPTH; k++) cyc(3'b001, 8'(8'h80 + k), 3'b000);
        chk("ch0_full", 32'(full[0]), 32'h1);
        cyc(3'b001, 8'h55, 3'b001);
        chk("ch0_full_after_rw", 32'(full[0]), 32'h1);
        for (int k = 1; k < DEPTH; k++) begin
            chk($sformatf("ch0_drain%0d", k), 32'(ch_dout(0)), 32'(8'h80 + k));
            cyc(3'b000, 8'h00, 3'b001);
        end
        chk("ch0_last_is_55", 32'(ch_dout(0)), 32'h55);
        cyc(3'b000, 8'h00, 3'b001);
        chk("ch0_drained", 32'(valid_out[0]), 32'h0);

        // Reset mid-packet empties channels and does not pulse soft_rst.
        cyc(3'b010, 8'h61, 3'b000);
        cyc(3'b010, 8'h62, 3'b000);
        rst      = 1'b1;
        wr_en    = '1;
        read_enb = '1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_en    = '0;
        read_enb = '0;
        chk("midrst_valid", 32'(valid_out), 32'h0);
        chk("midrst_srst",  32'(soft_rst),  32'h0);
        cyc(3'b000, 8'h00, 3'b000);
        chk("midrst_srst_next", 32'(soft_rst), 32'h0);

`ifdef ROUTER_DST_SOFTRST_EN
        // ch2 loaded first, then ch0, ch1: timeouts fire on successive edges.
        cyc(3'b100, 8'h77, 3'b000);
        cyc(3'b001, 8'hA0, 3'b000);
        cyc(3'b010, 8'hB1, 3'b000);
        seen_srst = '0;
        for (int k = 0; k < 27; k++) begin
            cyc(3'b000, 8'h00, 3'b000);
            seen_srst |= soft_rst;
        end
        chk("to_no_early_srst", 32'(seen_srst), 32'h0);
        chk("to_valid_before",  32'(valid_out), 32'h7);
        cyc(3'b100, 8'h99, 3'b000);
        chk("to_srst_ch2",   32'(soft_rst),    32'h4);
        chk("to_valid_ch2",  32'(valid_out),   32'h3);
        chk("to_ch0_intact", 32'(ch_dout(0)),  32'hA0);
        chk("to_ch1_intact", 32'(ch_dout(1)),  32'hB1);
        chk("to_ch2_dout0",  32'(ch_dout(2)),  32'h0);
        cyc(3'b000, 8'h00, 3'b000);
        chk("to_srst_ch0",  32'(soft_rst),  32'h1);
        chk("to_valid_ch0", 32'(valid_out), 32'h2);
        cyc(3'b000, 8'h00, 3'b000);
        chk("to_srst_ch1", 32'(soft_rst),  32'h2);
        cyc(3'b000, 8'h00, 3'b000);
        chk("to_srst_end",  32'(soft_rst),  32'h0);
        chk("to_all_empty", 32'(valid_out), 32'h0);

        // 29 stalls, a pop, 29 more stalls: no timeout.
        cyc(3'b001, 8'hC1, 3'b000);
        cyc(3'b001, 8'hC2, 3'b000);
        seen_srst = '0;
        for (int k = 0; k < 28; k++) begin
            cyc(3'b000, 8'h00, 3'b000);
            seen_srst |= soft_rst;
        end
        cyc(3'b000, 8'h00, 3'b001);
        seen_srst |= soft_rst;
        for (int k = 0; k < 29; k++) begin
            cyc(3'b000, 8'h00, 3'b000);
            seen_srst |= soft_rst;
        end
        chk("stall_cleared_srst", 32'(seen_srst),    32'h0);
        chk("stall_cleared_vld",  32'(valid_out[0]), 32'h1);
        chk("stall_cleared_data", 32'(ch_dout(0)),   32'hC2);
        cyc(3'b000, 8'h00, 3'b001);
        chk("stall_cleared_pop", 32'(valid_out[0]), 32'h0);
`else
        // Without the timeout feature data waits indefinitely.
        cyc(3'b010, 8'h3C, 3'b000);
        seen_srst = '0;
        for (int k = 0; k < 100; k++) begin
            cyc(3'b000, 8'h00, 3'b000);
            seen_srst |= soft_rst;
        end
        chk("hold_srst",  32'(seen_srst),    32'h0);
        chk("hold_valid", 32'(valid_out[1]), 32'h1);
        chk("hold_data",  32'(ch_dout(1)),   32'h3C);
        cyc(3'b000, 8'h00, 3'b010);
        chk("hold_popped", 32'(valid_out[1]), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
